// File: rtl/execute_stage_pkg.sv
// Shared encodings and the latched-instruction payload for the execute stage.
package execute_stage_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned IMM_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADA = 3'd1,
    ST_LOADB = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WB    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SHIFT_NONE = 2'b00,
    SHIFT_LSL1 = 2'b01,
    SHIFT_LSR1 = 2'b10,
    SHIFT_ASR1 = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rn;
    logic [REG_IDX_W-1:0] rm;
    logic [REG_IDX_W-1:0] rd;
    logic [1:0]           aluop;
    logic [1:0]           shift;
    logic                 asel;
    logic                 bsel;
    logic [IMM_W-1:0]     imm5;
    logic                 wb_en;
  } instr_t;

endpackage

// File: rtl/execute_stage_alu_shift.sv
// Combinational B shifter, ALU and Z/N/V flag generation.
module alu_shift
  import execute_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       aluop,
  input  logic [1:0]       shift,
  output logic [WIDTH-1:0] result_c,
  output logic             z_c,
  output logic             n_c,
  output logic             v_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_sh;

  always_comb begin
    b_sh = b;
    case (shift)
      SHIFT_LSL1: b_sh = {b[MSB-1:0], 1'b0};
      SHIFT_LSR1: b_sh = {1'b0, b[MSB:1]};
      SHIFT_ASR1: b_sh = {b[MSB], b[MSB:1]};
      default:    b_sh = b;
    endcase
  end

  // Overflow only has meaning for the two arithmetic ops.
  always_comb begin
    result_c = '0;
    v_c      = 1'b0;
    case (aluop)
      ALU_ADD: begin
        result_c = a + b_sh;
        v_c      = (a[MSB] == b_sh[MSB]) && (result_c[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result_c = a + ~b_sh + WIDTH'(1);
        v_c      = (a[MSB] != b_sh[MSB]) && (result_c[MSB] != a[MSB]);
      end
      ALU_AND: result_c = a & b_sh;
      ALU_MVN: result_c = ~b_sh;
      default: result_c = '0;
    endcase
  end

  assign z_c = (result_c == '0);
  assign n_c = result_c[MSB];

endmodule

// File: rtl/execute_stage.sv
// Five-state execute stage: latch instruction, read A, read B, run ALU, strobe write stage.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [2:0]       rd,
  input  logic [1:0]       aluop,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [4:0]       imm5,
  input  logic             wb_en,
  input  logic [WIDTH-1:0] reg0,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [WIDTH-1:0] reg3,
  input  logic [WIDTH-1:0] reg4,
  input  logic [WIDTH-1:0] reg5,
  input  logic [WIDTH-1:0] reg6,
  input  logic [WIDTH-1:0] reg7,
  output logic [WIDTH-1:0] C,
  output logic             write,
  output logic [2:0]       writenum,
  output logic             vsel,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             busy,
  output logic             done
);

  state_e           state, state_d;
  instr_t           instr;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             write_d, done_d, busy_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_z, alu_n, alu_v;
  logic [1:0]       shift_eff;

  assign regs[0] = reg0;
  assign regs[1] = reg1;
  assign regs[2] = reg2;
  assign regs[3] = reg3;
  assign regs[4] = reg4;
  assign regs[5] = reg5;
  assign regs[6] = reg6;
  assign regs[7] = reg7;

  // An immediate B operand bypasses the shifter.
  assign shift_eff = instr.bsel ? SHIFT_NONE : instr.shift;

  alu_shift #(.WIDTH(WIDTH)) u_alu_shift (
    .a        (a_reg),
    .b        (b_reg),
    .aluop    (instr.aluop),
    .shift    (shift_eff),
    .result_c (alu_result),
    .z_c      (alu_z),
    .n_c      (alu_n),
    .v_c      (alu_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      write <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      write <= write_d;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

  // Strobes are computed one state early so they are registered into WB.
  always_comb begin
    state_d = state;
    write_d = 1'b0;
    done_d  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_d = ST_LOADA;
      ST_LOADA: state_d = ST_LOADB;
      ST_LOADB: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_WB;
        write_d = instr.wb_en;
        done_d  = 1'b1;
      end
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      C        <= '0;
      Z        <= 1'b0;
      N        <= 1'b0;
      V        <= 1'b0;
      writenum <= '0;
      vsel     <= 1'b0;
    end else begin
      vsel <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            instr <= '{rn: rn, rm: rm, rd: rd, aluop: aluop, shift: shift,
                       asel: asel, bsel: bsel, imm5: imm5, wb_en: wb_en};
          end
        end
        ST_LOADA: a_reg <= instr.asel ? '0 : regs[instr.rn];
        ST_LOADB: b_reg <= instr.bsel ? {{(WIDTH-IMM_W){instr.imm5[IMM_W-1]}}, instr.imm5}
                                      : regs[instr.rm];
        ST_EXEC: begin
          C        <= alu_result;
          Z        <= alu_z;
          N        <= alu_n;
          V        <= alu_v;
          writenum <= instr.rd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage: expectations queued at issue, checked on done.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  aluop, shift;
  logic        asel, bsel, wb_en;
  logic [4:0]  imm5;
  logic [15:0] r [8];
  logic [15:0] C;
  logic        write, vsel, Z, N, V, busy, done;
  logic [2:0]  writenum;

  typedef struct {
    logic [15:0] c;
    logic        z, n, v, wr;
    logic [2:0]  wn;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  execute_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rn(rn), .rm(rm), .rd(rd), .aluop(aluop), .shift(shift),
    .asel(asel), .bsel(bsel), .imm5(imm5), .wb_en(wb_en),
    .reg0(r[0]), .reg1(r[1]), .reg2(r[2]), .reg3(r[3]),
    .reg4(r[4]), .reg5(r[5]), .reg6(r[6]), .reg7(r[7]),
    .C(C), .write(write), .writenum(writenum), .vsel(vsel),
    .Z(Z), .N(N), .V(V), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: pops one expectation per done pulse; write must never appear without done.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (write === 1'b1 && done !== 1'b1) begin
        bad++;
        $display("FAIL write_outside_wb: write=%b done=%b at cyc %0d", write, done, cyc);
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: done=1 with no instruction pending at cyc %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          total++;
          if (C !== e.c || Z !== e.z || N !== e.n || V !== e.v ||
              write !== e.wr || writenum !== e.wn || vsel !== 1'b0) begin
            bad++;
            $display("FAIL result: got C=%h Z=%b N=%b V=%b write=%b wn=%0d vsel=%b, want C=%h Z=%b N=%b V=%b write=%b wn=%0d vsel=0",
                     C, Z, N, V, write, writenum, vsel, e.c, e.z, e.n, e.v, e.wr, e.wn);
          end
          total++;
          if (cyc - e.issue != 4) begin
            bad++;
            $display("FAIL latency: got %0d cycles, want 4", cyc - e.issue);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%b after 50 cycles", busy);
    end
  endtask

  task automatic set_fields(input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [2:0] a_rd,
                            input logic [1:0] a_op, input logic [1:0] a_sh, input logic a_asel,
                            input logic a_bsel, input logic [4:0] a_imm, input logic a_wb);
    rn = a_rn; rm = a_rm; rd = a_rd; aluop = a_op; shift = a_sh;
    asel = a_asel; bsel = a_bsel; imm5 = a_imm; wb_en = a_wb;
  endtask

  task automatic issue(input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [2:0] a_rd,
                       input logic [1:0] a_op, input logic [1:0] a_sh, input logic a_asel,
                       input logic a_bsel, input logic [4:0] a_imm, input logic a_wb,
                       input logic [15:0] ec, input logic ez, input logic en, input logic ev);
    set_fields(a_rn, a_rm, a_rd, a_op, a_sh, a_asel, a_bsel, a_imm, a_wb);
    start = 1'b1;
    sb.push_back('{c: ec, z: ez, n: en, v: ev, wr: a_wb, wn: a_rd, issue: cyc});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_fields(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({C, Z, N, V, write, writenum, vsel, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_state: C=%h Z=%b N=%b V=%b write=%b wn=%0d vsel=%b busy=%b done=%b, want all 0",
               C, Z, N, V, write, writenum, vsel, busy, done);
    end
    rst_n = 1'b1;

    // ADD 5+3 -> 8
    wait_idle(); r[1] = 16'h0005; r[2] = 16'h0003;
    issue(3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
    // signed overflow on ADD and SUB
    wait_idle(); r[1] = 16'h7FFF; r[2] = 16'h0001;
    issue(3'd1, 3'd2, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
    wait_idle(); r[1] = 16'h8000; r[2] = 16'h0001;
    issue(3'd1, 3'd2, 3'd5, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    // CMP: equal operands, write suppressed
    wait_idle(); r[1] = 16'h1234; r[2] = 16'h1234;
    issue(3'd1, 3'd2, 3'd6, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    // shifter paths with A forced to zero
    wait_idle(); r[2] = 16'h8001;
    issue(3'd1, 3'd2, 3'd2, 2'b00, 2'b01, 1'b1, 1'b0, 5'd0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    wait_idle();
    issue(3'd1, 3'd2, 3'd2, 2'b00, 2'b10, 1'b1, 1'b0, 5'd0, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
    wait_idle();
    issue(3'd1, 3'd2, 3'd2, 2'b00, 2'b11, 1'b1, 1'b0, 5'd0, 1'b1, 16'hC000, 1'b0, 1'b1, 1'b0);
    wait_idle();
    issue(3'd1, 3'd2, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0);
    // immediate sign-extension; shift field must be ignored
    wait_idle();
    issue(3'd1, 3'd2, 3'd1, 2'b00, 2'b01, 1'b1, 1'b1, 5'b10000, 1'b1, 16'hFFF0, 1'b0, 1'b1, 1'b0);
    // AND and MVN
    wait_idle(); r[3] = 16'hF0F0; r[4] = 16'hFF00;
    issue(3'd3, 3'd4, 3'd7, 2'b10, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 16'hF000, 1'b0, 1'b1, 1'b0);
    wait_idle(); r[4] = 16'h00FF;
    issue(3'd3, 3'd4, 3'd7, 2'b11, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 16'hFF00, 1'b0, 1'b1, 1'b0);

    // start held high for 10 edges: accepted at the first edge and again five edges later
    wait_idle(); r[1] = 16'h0001; r[2] = 16'h0002;
    set_fields(3'd1, 3'd2, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1);
    sb.push_back('{c: 16'h0003, z: 1'b0, n: 1'b0, v: 1'b0, wr: 1'b1, wn: 3'd7, issue: cyc});
    sb.push_back('{c: 16'h0003, z: 1'b0, n: 1'b0, v: 1'b0, wr: 1'b1, wn: 3'd7, issue: cyc + 5});
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;

    // async reset while in EXEC
    wait_idle(); r[1] = 16'h1111; r[2] = 16'h2222;
    set_fields(3'd1, 3'd2, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({C, Z, N, V, write, writenum, vsel, busy, done} !== '0) begin
      bad++;
      $display("FAIL async_reset: C=%h Z=%b N=%b V=%b write=%b wn=%0d vsel=%b busy=%b done=%b, want all 0",
               C, Z, N, V, write, writenum, vsel, busy, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || write !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: busy=%b write=%b, want 0 0", busy, write);
    end

    // recovery after reset
    wait_idle(); r[1] = 16'h0005; r[2] = 16'h0003;
    issue(3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected results never observed, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
